// File: rtl/uart_pipe_sched_pkg.sv
// Shared encodings and default timing constants for the FIFO/UART pipeline scheduler.
package sched_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_CLEAR = 2'd3
  } schedState_t;

  localparam int CLEAR_CYCLES_DEF  = 2;
  localparam int DRAIN_TIMEOUT_DEF = 4096;
  localparam int IDLE_W            = 12;
  localparam int DROP_W            = 8;

endpackage

// File: rtl/uart_pipe_sched_rr_arbiter2.sv
// Two-way round-robin arbiter: index W (write) and R (read), last-served flag
// advances only when the caller reports a real grant through upd.
module rr_arbiter2 (
  input  logic clk,
  input  logic reset,
  input  logic reqW,
  input  logic reqR,
  input  logic upd,
  output logic gntW,
  output logic gntR
);

  logic lastW;

  // lastW=0 (read served last, or nothing yet) favours the writer
  always_comb begin
    gntW = reqW & (~reqR | ~lastW);
    gntR = reqR & (~reqW | lastW);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lastW <= 1'b0;
    end else if (upd) begin
      lastW <= gntW;
    end
  end

endmodule

// File: rtl/uart_pipe_sched.sv
// Scheduler that owns the single-port FIFO: arbitrates writer/reader one op at a
// time and sequences the pipeline through run, hold, drain and clear.
module uart_pipe_sched
  import sched_pkg::*;
#(
  parameter int CLEAR_CYCLES  = CLEAR_CYCLES_DEF,
  parameter int DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic              pause,
  input  logic              flush,
  input  logic              fifo_busy,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  output logic              fifo_we,
  output logic              fifo_re,
  output logic              fifo_clear,
  output logic              wr_gnt,
  output logic              rd_gnt,
  output logic              in_enable,
  output logic              out_enable,
  output logic [DROP_W-1:0] drop_count,
  output logic [1:0]        state
);

  localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CLR_W-1:0]  CLR_LAST  = CLR_W'(CLEAR_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(DRAIN_TIMEOUT - 1);

  function automatic logic [DROP_W-1:0] satInc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  schedState_t       stateQ;
  schedState_t       stateNext;
  logic [IDLE_W-1:0] idleCnt;
  logic [CLR_W-1:0]  clrCnt;
  logic [DROP_W-1:0] dropCnt;

  logic wrAllow, rdAllow, gapCycle;
  logic wrElig_p0, rdElig_p0;
  logic gntW_p0, gntR_p0, we_p0, drop_p0, arbUpd_p0;
  logic fifoWe_p1, fifoRe_p1, wrGnt_p1, rdGnt_p1, fifoClear_p1;

  // Stage p0: eligibility and arbitration from the current state and inputs
  assign wrAllow   = (stateQ == ST_RUN);
  assign rdAllow   = (stateQ == ST_RUN) || (stateQ == ST_DRAIN);
  assign gapCycle  = wrGnt_p1 | rdGnt_p1;
  assign wrElig_p0 = wr_req & ~fifo_busy & wrAllow & ~gapCycle;
  assign rdElig_p0 = rd_req & ~fifo_empty & ~fifo_busy & rdAllow & ~gapCycle;

  rr_arbiter2 uArb (
    .clk   (clk),
    .reset (reset),
    .reqW  (wrElig_p0),
    .reqR  (rdElig_p0),
    .upd   (arbUpd_p0),
    .gntW  (gntW_p0),
    .gntR  (gntR_p0)
  );

  assign we_p0     = gntW_p0 & ~fifo_full;
  assign drop_p0   = gntW_p0 & fifo_full;
  assign arbUpd_p0 = gntR_p0 | we_p0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ <= ST_RUN;
    end else begin
      stateQ <= stateNext;
    end
  end

  // Drain exit waits until no read strobe is outstanding
  always_comb begin
    stateNext = stateQ;
    case (stateQ)
      ST_RUN: begin
        if (flush)      stateNext = ST_DRAIN;
        else if (pause) stateNext = ST_HOLD;
      end
      ST_HOLD: begin
        if (flush)      stateNext = ST_DRAIN;
        else if (pause) stateNext = ST_RUN;
      end
      ST_DRAIN: begin
        if ((fifo_empty && !fifoRe_p1) || (!rdGnt_p1 && idleCnt == IDLE_LAST))
          stateNext = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (clrCnt == CLR_LAST) stateNext = ST_RUN;
      end
      default: stateNext = ST_RUN;
    endcase
  end

  always_comb begin
    in_enable  = 1'b0;
    out_enable = 1'b0;
    case (stateQ)
      ST_RUN: begin
        in_enable  = 1'b1;
        out_enable = 1'b1;
      end
      ST_DRAIN: out_enable = 1'b1;
      default: begin
        in_enable  = 1'b0;
        out_enable = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idleCnt <= '0;
      clrCnt  <= '0;
      dropCnt <= '0;
    end else begin
      if (stateQ == ST_DRAIN) begin
        idleCnt <= rdGnt_p1 ? '0 : idleCnt + 1'b1;
      end else begin
        idleCnt <= '0;
      end

      if (stateQ == ST_CLEAR) begin
        clrCnt <= (clrCnt == CLR_LAST) ? '0 : clrCnt + 1'b1;
      end else begin
        clrCnt <= '0;
      end

      if (stateQ == ST_CLEAR) begin
        dropCnt <= '0;
      end else if (drop_p0) begin
        dropCnt <= satInc(dropCnt);
      end
    end
  end

  // Stage p1: registered strobes and grants
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifoWe_p1    <= 1'b0;
      fifoRe_p1    <= 1'b0;
      wrGnt_p1     <= 1'b0;
      rdGnt_p1     <= 1'b0;
      fifoClear_p1 <= 1'b0;
    end else begin
      fifoWe_p1    <= we_p0;
      fifoRe_p1    <= gntR_p0;
      wrGnt_p1     <= gntW_p0;
      rdGnt_p1     <= gntR_p0;
      fifoClear_p1 <= (stateNext == ST_CLEAR);
    end
  end

  assign fifo_we    = fifoWe_p1;
  assign fifo_re    = fifoRe_p1;
  assign wr_gnt     = wrGnt_p1;
  assign rd_gnt     = rdGnt_p1;
  assign fifo_clear = fifoClear_p1;
  assign drop_count = dropCnt;
  assign state      = stateQ;

endmodule

// File: tb/tb_uart_pipe_sched.sv
// Directed bench for uart_pipe_sched: FIFO status inputs are driven by hand.
module tb_uart_pipe_sched;

  logic       clk, reset;
  logic       wr_req, rd_req, pause, flush, fifo_busy, fifo_full, fifo_empty;
  logic       fifo_we, fifo_re, fifo_clear, wr_gnt, rd_gnt, in_enable, out_enable;
  logic [7:0] drop_count;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;
  int nW, nR, nWe, k, bytesLeft;

  uart_pipe_sched #(
    .CLEAR_CYCLES  (2),
    .DRAIN_TIMEOUT (4096)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_req     (wr_req),
    .rd_req     (rd_req),
    .pause      (pause),
    .flush      (flush),
    .fifo_busy  (fifo_busy),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_we    (fifo_we),
    .fifo_re    (fifo_re),
    .fifo_clear (fifo_clear),
    .wr_gnt     (wr_gnt),
    .rd_gnt     (rd_gnt),
    .in_enable  (in_enable),
    .out_enable (out_enable),
    .drop_count (drop_count),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; wr_req = 0; rd_req = 0; pause = 0; flush = 0;
    fifo_busy = 0; fifo_full = 0; fifo_empty = 1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_state", state, 0);
    chk("rst_in_en", in_enable, 1);
    chk("rst_out_en", out_enable, 1);
    chk("rst_we", fifo_we, 0);
    chk("rst_re", fifo_re, 0);
    chk("rst_clear", fifo_clear, 0);
    chk("rst_wgnt", wr_gnt, 0);
    chk("rst_rgnt", rd_gnt, 0);
    chk("rst_drop", drop_count, 0);

    // basic write then read
    wr_req = 1;
    tick();
    chk("basic_we", fifo_we, 1);
    chk("basic_wgnt", wr_gnt, 1);
    chk("basic_re0", fifo_re, 0);
    wr_req = 0; rd_req = 1; fifo_empty = 0;
    tick();
    chk("basic_gap_re", fifo_re, 0);
    chk("basic_gap_we", fifo_we, 0);
    tick();
    chk("basic_re", fifo_re, 1);
    chk("basic_rgnt", rd_gnt, 1);
    chk("basic_drop", drop_count, 0);
    rd_req = 0; fifo_empty = 1;
    tick();
    chk("basic_re_end", fifo_re, 0);

    // contention: W,R,W,R... with a gap after each grant
    fifo_empty = 0; wr_req = 1; rd_req = 1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("cont_we%0d", i), fifo_we, (i % 4 == 0));
      chk($sformatf("cont_re%0d", i), fifo_re, (i % 4 == 2));
    end
    wr_req = 0; rd_req = 0;

    // busy blocks grants
    fifo_busy = 1; wr_req = 1;
    tick();
    chk("busy_we0", fifo_we, 0);
    fifo_busy = 0;
    tick();
    chk("busy_we1", fifo_we, 1);
    wr_req = 0;
    tick();

    // full FIFO: every write is granted and dropped
    fifo_full = 1; wr_req = 1; nW = 0; nWe = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      nW  += int'(wr_gnt);
      nWe += int'(fifo_we);
      if (i == 8)   chk("full_drop5", drop_count, 5);
      if (i == 508) chk("full_drop255", drop_count, 255);
    end
    wr_req = 0; fifo_full = 0;
    chk("full_wgnt", nW, 300);
    chk("full_we", nWe, 0);
    chk("full_drop_sat", drop_count, 255);

    // pause -> HOLD, no grants, pause again -> RUN
    pause = 1;
    tick();
    pause = 0;
    chk("hold_state", state, 1);
    chk("hold_in_en", in_enable, 0);
    chk("hold_out_en", out_enable, 0);
    wr_req = 1; rd_req = 1; nW = 0; nR = 0;
    repeat (6) begin
      tick();
      nW += int'(wr_gnt);
      nR += int'(rd_gnt);
    end
    chk("hold_wgnt", nW, 0);
    chk("hold_rgnt", nR, 0);
    pause = 1;
    tick();
    pause = 0;
    chk("resume_state", state, 0);
    chk("resume_edge_we", fifo_we, 0);
    tick();
    chk("resume_re", fifo_re, 1);
    chk("resume_we", fifo_we, 0);
    wr_req = 0; rd_req = 0;
    tick();

    // flush with 3 bytes queued
    bytesLeft = 3; fifo_empty = 0;
    flush = 1;
    tick();
    flush = 0;
    chk("drain_state", state, 2);
    chk("drain_in_en", in_enable, 0);
    chk("drain_out_en", out_enable, 1);
    rd_req = 1; wr_req = 1; nW = 0; nR = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      nW += int'(wr_gnt);
      nR += int'(fifo_re);
      chk($sformatf("drain_re%0d", i), fifo_re, (i % 2 == 0) && (i < 6));
      chk($sformatf("drain_st%0d", i), state, (i == 6) ? 3 : 2);
      if (fifo_re) begin
        bytesLeft--;
        fifo_empty = (bytesLeft == 0);
      end
    end
    rd_req = 0; wr_req = 0;
    chk("drain_reads", nR, 3);
    chk("drain_wgnt", nW, 0);
    chk("clear_hi0", fifo_clear, 1);
    tick();
    chk("clear_state1", state, 3);
    chk("clear_hi1", fifo_clear, 1);
    tick();
    chk("post_clear_state", state, 0);
    chk("post_clear_clr", fifo_clear, 0);
    chk("post_clear_drop", drop_count, 0);

    // pause+flush together: flush wins; then reset while in CLEAR
    pause = 1; flush = 1;
    tick();
    pause = 0; flush = 0;
    chk("both_state", state, 2);
    tick();
    chk("both_clear_state", state, 3);
    chk("both_clear_hi", fifo_clear, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_clear_state", state, 0);
    chk("rst_clear_clr", fifo_clear, 0);
    chk("rst_clear_in_en", in_enable, 1);
    @(posedge clk);
    #1 reset = 1'b0;

    // drain timeout with no reader
    fifo_empty = 0; rd_req = 0;
    flush = 1;
    tick();
    flush = 0;
    chk("tmo_drain", state, 2);
    k = 0;
    while (state == 2'd2 && k < 5000) begin
      tick();
      k++;
    end
    chk("tmo_cycles", k, 4096);
    chk("tmo_state", state, 3);
    repeat (2) tick();
    chk("tmo_run", state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_pipe_sched.md
# uart_pipe_sched

Scheduler for the parallel-in to FIFO to UART-out datapath. It owns the single-port FIFO and grants it to two requesters: the input stage (write) and the output stage (read), one operation at a time, with round-robin fairness. It also sequences the pipeline through run, pause and flush. Flush drains the FIFO to the UART, then clears it. The block replaces the hard-wired stage enables and the direct button-to-FIFO reset.

## Interface
Parameters:
- CLEAR_CYCLES, 2: cycles `fifo_clear` is held in CLEAR.
- DRAIN_TIMEOUT, 4096: idle cycles in DRAIN before CLEAR is forced.

Ports:
- `clk`, in, 1: the single clock (UART-rate clock).
- `reset`, in, 1: asynchronous, active-high.
- `wr_req`, in, 1: input stage has a byte; held until `wr_gnt`.
- `rd_req`, in, 1: output stage wants a byte; held until `rd_gnt`.
- `pause`, in, 1: one-cycle pulse; toggles RUN and HOLD.
- `flush`, in, 1: one-cycle pulse; starts drain-and-clear.
- `fifo_busy`, in, 1: FIFO status.
- `fifo_full`, in, 1: FIFO status.
- `fifo_empty`, in, 1: FIFO status.
- `fifo_we`, out, 1: one-cycle FIFO write strobe.
- `fifo_re`, out, 1: one-cycle FIFO read strobe.
- `fifo_clear`, out, 1: FIFO reset request.
- `wr_gnt`, out, 1: write accepted, whether stored or dropped.
- `rd_gnt`, out, 1: read performed.
- `in_enable`, out, 1: enable for the input stage.
- `out_enable`, out, 1: enable for the output stage.
- `drop_count`, out, 8: saturating count of bytes dropped on full.
- `state`, out, 2: RUN=0, HOLD=1, DRAIN=2, CLEAR=3.

## Operation
- States:
  - RUN: `in_enable`=`out_enable`=1; reads and writes are arbitrated.
  - HOLD: both enables 0; no grants are issued.
  - DRAIN: `in_enable`=0, `out_enable`=1; only reads are granted, and `wr_req` is neither granted nor dropped.
  - CLEAR: both enables 0; `fifo_clear`=1; no grants.
- Transitions:
  - `pause` in RUN goes to HOLD; `pause` in HOLD goes to RUN.
  - `flush` in RUN or HOLD goes to DRAIN.
  - `pause` and `flush` are ignored in DRAIN and CLEAR.
  - If `pause` and `flush` arrive in the same cycle, `flush` wins.
  - DRAIN goes to CLEAR when `fifo_empty`=1 and no read strobe is in flight, or when the idle counter reaches DRAIN_TIMEOUT.
  - CLEAR goes to RUN after CLEAR_CYCLES cycles.
- Eligibility:
  - Write is eligible when `wr_req`=1 and `fifo_busy`=0.
  - Read is eligible when `rd_req`=1, `fifo_empty`=0 and `fifo_busy`=0.
- Arbitration:
  - When both are eligible, the requester not served last wins.
  - The last-served flag is 0 after reset, so write wins first.
  - The flag updates only on an actual grant.
- Full handling: a write in RUN while `fifo_full`=1 gives `wr_gnt`=1 with `fifo_we`=0. The byte is dropped and `drop_count` increments, saturating at 255. Drops do not update the last-served flag.
- Strobes: `wr_gnt` coincides with `fifo_we` (or with a drop); `rd_gnt` coincides with `fifo_re`. All four are single-cycle pulses.
- Counters:
  - The DRAIN idle counter is 12-bit. It counts cycles without `rd_gnt`, clears on each `rd_gnt` and clears on entry to DRAIN.
  - The CLEAR counter counts up to CLEAR_CYCLES-1.
  - `drop_count` clears during CLEAR.
- Reset values:
  - State is RUN, so `in_enable`=`out_enable`=1.
  - `fifo_we`, `fifo_re`, `fifo_clear`, `wr_gnt` and `rd_gnt` are 0.
  - `drop_count` is 0 and all counters are 0.
  - Reset mid-DRAIN or mid-CLEAR aborts immediately to RUN; any strobe in flight is cancelled.

## Timing
- All outputs are registered, except the enables, which decode combinationally from the registered state.
- Grant latency is one cycle: a request sampled eligible at edge N gives a strobe and grant high for cycle N to N+1.
- After any grant cycle, one mandatory gap cycle follows, so the next grant comes at edge N+2 at the earliest. This lets `fifo_busy` assert.
- A requester may drop its request in the grant cycle. If the request is still high at the next sampling edge, it is treated as a new request.
- State changes take effect at the edge after the pulse. A grant issued on that same edge still completes.
- DRAIN to CLEAR is evaluated on the edge after the last `rd_gnt`, so the final strobe is never cut short.
- Throughput is at most one FIFO operation every 2 cycles.

## Structure
- Package `sched_pkg`: state encoding constants and the default values of CLEAR_CYCLES and DRAIN_TIMEOUT.
- Sub-module `rr_arbiter2`: a two-way round-robin arbiter with a last-served flag and update-on-grant input, instantiated once.
- The top level contains the FSM, the drop, drain and clear counters, and the strobe registers.

## Test plan
- **Basic write then read:** after reset, `wr_req`=1 with FIFO empty, then `rd_req`=1 → `fifo_we` pulses at cycle 1, `fifo_re` at cycle 3 at the earliest, `drop_count`=0.
- **Contention:** `wr_req` and `rd_req` held high for 8 grants → order W,R,W,R,W,R,W,R, with a gap cycle between each.
- **Full FIFO:** `fifo_full`=1 and 300 write requests → 300 `wr_gnt`, 0 `fifo_we`, `drop_count` saturates at 255.
- **Flush with 3 bytes queued:** → state goes to DRAIN, exactly 3 `fifo_re`, then `fifo_clear` high for 2 cycles, then RUN with `drop_count`=0.
- **Drain timeout:** flush with `rd_req` held 0 and FIFO non-empty → CLEAR entered 4096 cycles after DRAIN entry.
- **Pause and reset:** a `pause` pulse leads to HOLD with no grants despite requests; a second pulse resumes RUN. Asserting `reset` in CLEAR gives RUN with `fifo_clear`=0 immediately.
